fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, feeding a small FIFO of
// {inst, pc+2} entries. Define FETCH_PREFETCH_EN for a 2-entry buffer; otherwise 1 entry.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_read,
  output logic [15:0] mem_address,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        take,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned Depth = 2;
`else
  localparam int unsigned Depth = 1;
`endif
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e          state_q, state_d;
  logic [15:0]     fetch_pc_q, fetch_pc_d;
  logic [15:0]     addr_q, addr_d;
  logic [CntW-1:0] count_q, count_d, count_pop;
  logic [15:0]     buf_inst_q [Depth];
  logic [15:0]     buf_inst_d [Depth];
  logic [15:0]     buf_pc_q   [Depth];
  logic [15:0]     buf_pc_d   [Depth];
  logic            pop, push;

  assign inst_valid  = (count_q != '0);
  assign inst        = inst_valid ? buf_inst_q[0] : 16'h0000;
  assign inst_pc     = inst_valid ? buf_pc_q[0] : 16'h0000;
  assign mem_read    = (state_q != StIdle);
  assign mem_address = addr_q;

  // Redirect wins over both pop and push; a flushed cycle neither consumes nor fills.
  assign pop       = take && inst_valid && !redirect;
  assign push      = (state_q == StFetch) && mem_resp && !redirect;
  assign count_pop = count_q - CntW'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      StIdle: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (count_pop < CntW'(Depth)) begin
          state_d = StFetch;
          addr_d  = fetch_pc_q;
        end
      end
      StFetch: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = mem_resp ? StIdle : StDrain;
        end else if (mem_resp) begin
          fetch_pc_d = fetch_pc_q + 16'd2;
          state_d    = StIdle;
        end
      end
      StDrain: begin
        // The stale read must still complete before a new one is issued.
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end
        if (mem_resp) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    count_d    = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(Depth) - 1; i++) begin
          buf_inst_d[i] = buf_inst_q[i + 1];
          buf_pc_d[i]   = buf_pc_q[i + 1];
        end
      end
      if (push) begin
        for (int i = 0; i < int'(Depth); i++) begin
          if (count_pop == CntW'(i)) begin
            buf_inst_d[i] = mem_rdata;
            buf_pc_d[i]   = fetch_pc_q + 16'd2;
          end
        end
      end
      count_d = count_pop + CntW'(push);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      addr_q     <= 16'h0000;
      count_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        buf_inst_q[i] <= 16'h0000;
        buf_pc_q[i]   <= 16'h0000;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then random traffic against an instruction-stream
// model whose expected entries are queued at each redirect and popped by a separate monitor.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        take = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  int checks = 0;
  int failures = 0;
  int n_takes = 0;
  bit mon_en = 1'b0;
  bit hold_pend = 1'b0;
  logic [15:0] hold_addr = 16'h0000;
  logic [31:0] mon_e;
  logic [31:0] exp_q [$];

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_address(mem_address),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .take       (take),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5AA5;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    take = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    mem_resp = 1'b0;
    mem_rdata = 16'h0000;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  // Expected delivery stream from a start address: sequential words, pc+2 alongside.
  task automatic refill(input logic [15:0] a);
    logic [15:0] p;
    p = a;
    exp_q.delete();
    for (int k = 0; k < 40; k++) begin
      exp_q.push_back({mem_word(p), p + 16'd2});
      p = p + 16'd2;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (!inst_valid) begin
        check("empty_inst", inst, 16'h0000);
        check("empty_pc", inst_pc, 16'h0000);
      end
      if (take && inst_valid && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL take_unexpected: got pc %h with no expected entry", inst_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("take_inst", inst, mon_e[31:16]);
          check("take_pc", inst_pc, mon_e[15:0]);
          n_takes++;
        end
      end
      if (hold_pend) begin
        check("hold_read", 16'(mem_read), 16'd1);
        check("hold_addr", mem_address, hold_addr);
      end
      hold_pend = mem_read && !mem_resp;
      hold_addr = mem_address;
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd_addr [$];
    bit found;
    bit pend;
    int lat;
    int since_redir;
    int take_pct;

    // Reset values
    tick;
    tick;
    check("rst_mem_read", 16'(mem_read), 16'd0);
    check("rst_mem_address", mem_address, 16'h0000);
    check("rst_inst_valid", 16'(inst_valid), 16'd0);
    check("rst_inst", inst, 16'h0000);
    check("rst_inst_pc", inst_pc, 16'h0000);

    // First fetch, memory answers on the third cycle
    rst_n = 1'b1;
    tick;
    check("t30_mem_read", 16'(mem_read), 16'd1);
    check("t30_mem_address", mem_address, 16'h0000);
    tick;
    tick;
    mem_resp = 1'b1;
    mem_rdata = 16'h1234;
    tick;
    mem_resp = 1'b0;
    check("t30_valid", 16'(inst_valid), 16'd1);
    check("t30_inst", inst, 16'h1234);
    check("t30_inst_pc", inst_pc, 16'h0002);

    // take held low: reads stop once the buffer is full
    do_reset;
    rd_addr.delete();
    for (int c = 0; c < 20; c++) begin
      tick;
      if (mem_read) begin
        rd_addr.push_back(mem_address);
        mem_resp = 1'b1;
        mem_rdata = mem_word(mem_address);
      end else begin
        mem_resp = 1'b0;
      end
    end
    mem_resp = 1'b0;
    check("t31_read_count", 16'(rd_addr.size()), 16'(DEPTH));
    for (int i = 0; i < rd_addr.size(); i++) check("t31_read_addr", rd_addr[i], 16'(2 * i));
    check("t31_quiet", 16'(mem_read), 16'd0);
    check("t31_head_inst", inst, mem_word(16'h0000));
    check("t31_head_pc", inst_pc, 16'h0002);

    // One pop frees a slot; then pop and push in the same cycle
    take = 1'b1;
    tick;
    check("t34_fetch_read", 16'(mem_read), 16'd1);
    check("t34_fetch_addr", mem_address, 16'(2 * DEPTH));
    mem_resp = 1'b1;
    mem_rdata = mem_word(16'(2 * DEPTH));
    tick;
    take = 1'b0;
    mem_resp = 1'b0;
    check("t34_valid", 16'(inst_valid), 16'd1);
    check("t34_inst", inst, mem_word(16'(2 * DEPTH)));
    check("t34_inst_pc", inst_pc, 16'(2 * DEPTH + 2));
    take = 1'b1;
    tick;
    take = 1'b0;
    check("t34_single_entry", 16'(inst_valid), 16'd0);

    // Redirect while a read to 0x0004 is outstanding
    do_reset;
    take = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick;
      if (mem_read && mem_address == 16'h0004) begin
        found = 1'b1;
        mem_resp = 1'b0;
      end else if (mem_read) begin
        mem_resp = 1'b1;
        mem_rdata = mem_word(mem_address);
      end else begin
        mem_resp = 1'b0;
      end
    end
    check("t32_reach_0004", 16'(found), 16'd1);
    take = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'h3000;
    tick;
    redirect = 1'b0;
    check("t32_drain_read", 16'(mem_read), 16'd1);
    check("t32_drain_addr", mem_address, 16'h0004);
    check("t32_flushed", 16'(inst_valid), 16'd0);
    tick;
    tick;
    check("t32_held_read", 16'(mem_read), 16'd1);
    check("t32_held_addr", mem_address, 16'h0004);
    mem_resp = 1'b1;
    mem_rdata = 16'hDEAD;
    tick;
    mem_resp = 1'b0;
    check("t32_dropped", 16'(inst_valid), 16'd0);
    tick;
    check("t32_new_read", 16'(mem_read), 16'd1);
    check("t32_new_addr", mem_address, 16'h3000);
    mem_resp = 1'b1;
    mem_rdata = mem_word(16'h3000);
    tick;
    mem_resp = 1'b0;
    check("t32_inst", inst, mem_word(16'h3000));
    check("t32_inst_pc", inst_pc, 16'h3002);

    // Redirect in idle to 0xFFFE: pc wraps
    rst_n = 1'b0;
    take = 1'b0;
    tick;
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    rst_n = 1'b1;
    tick;
    redirect = 1'b0;
    check("t25_idle_stays", 16'(mem_read), 16'd0);
    tick;
    check("t33_addr", mem_address, 16'hFFFE);
    mem_resp = 1'b1;
    mem_rdata = 16'hABCD;
    tick;
    mem_resp = 1'b0;
    check("t33_valid", 16'(inst_valid), 16'd1);
    check("t33_inst", inst, 16'hABCD);
    check("t33_inst_pc", inst_pc, 16'h0000);
    take = 1'b1;
    tick;
    take = 1'b0;
    check("t33_next_read", 16'(mem_read), 16'd1);
    check("t33_next_addr", mem_address, 16'h0000);

    // Reset mid-fetch, then a stray response in idle is ignored
    #2;
    rst_n = 1'b0;
    #1;
    check("t35_read_off", 16'(mem_read), 16'd0);
    check("t35_valid_off", 16'(inst_valid), 16'd0);
    check("t35_addr_zero", mem_address, 16'h0000);
    tick;
    rst_n = 1'b1;
    mem_resp = 1'b1;
    mem_rdata = 16'hDEAD;
    tick;
    mem_resp = 1'b0;
    check("t27_stray_ignored", 16'(inst_valid), 16'd0);
    check("t35_restart_read", 16'(mem_read), 16'd1);
    check("t35_restart_addr", mem_address, 16'h0000);
    mem_resp = 1'b1;
    mem_rdata = mem_word(16'h0000);
    tick;
    mem_resp = 1'b0;
    check("t35_inst", inst, mem_word(16'h0000));
    check("t35_inst_pc", inst_pc, 16'h0002);

    // Random traffic: variable memory latency, take rate and redirects
    do_reset;
    refill(16'h0000);
    pend = 1'b0;
    lat = 0;
    since_redir = 0;
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (mem_read && !pend) begin
        pend = 1'b1;
        lat = $urandom_range(0, 3);
      end
      mem_resp = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          mem_resp = 1'b1;
          mem_rdata = mem_word(mem_address);
          pend = 1'b0;
        end else begin
          lat--;
        end
      end
      take_pct = ((c / 200) % 3 == 0) ? 15 : (((c / 200) % 3 == 1) ? 60 : 95);
      take = ($urandom_range(0, 99) < take_pct);
      since_redir++;
      if ($urandom_range(0, 19) == 0 || since_redir >= 30) begin
        redirect = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : (16'($urandom) & 16'hFFFE);
        since_redir = 0;
        refill(redirect_pc);
      end else begin
        redirect = 1'b0;
      end
    end
    tick;
    mon_en = 1'b0;
    take = 1'b0;
    redirect = 1'b0;
    mem_resp = 1'b0;
    check("rand_take_activity", 16'(n_takes > 200), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
